// File: rtl/icache_xwa_if.sv
// icache_xwa_if: processor fetch and backing-memory signals of the icache.
//   slave  : cache side (takes fetch requests, issues memory reads)
//   master : processor/memory side (issues fetches, answers memory reads)
//   proc_valid/proc_addr      fetch request, held until proc_ready
//   proc_ready/proc_rdata     one-cycle response strobe and instruction word
//   mem_req_valid/mem_req_addr   word read request to backing memory
//   mem_req_ready/mem_req_rdata  memory returns data this cycle
//   debug_miss                one-cycle pulse per detected miss
interface icache_xwa_if;
    logic        proc_valid;
    logic        proc_ready;
    logic [31:0] proc_addr;
    logic [31:0] proc_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_rdata;
    logic        debug_miss;

    modport slave (
        input  proc_valid, proc_addr, mem_req_ready, mem_req_rdata,
        output proc_ready, proc_rdata, mem_req_valid, mem_req_addr, debug_miss
    );

    modport master (
        output proc_valid, proc_addr, mem_req_ready, mem_req_rdata,
        input  proc_ready, proc_rdata, mem_req_valid, mem_req_addr, debug_miss
    );
endinterface

// File: rtl/icache_xwa.sv
// icache_xwa: read-only set-associative instruction cache with round-robin
// replacement and whole-line, in-order refill from a word-wide memory port.
// Ports:
//   clk     clock, all state updates on the rising edge
//   resetn  synchronous active-low reset (clears valid bits and rr pointers)
//   bus     icache_xwa_if.slave: processor fetch port, memory read port,
//           debug_miss pulse
module icache_xwa #(
    parameter int CACHE_SIZE = 4096,
    parameter int NUM_WAYS   = 4,
    parameter int NUM_BLOCKS = 4,
    parameter int BLOCK_SIZE = 4
) (
    input  logic         clk,
    input  logic         resetn,
    icache_xwa_if.slave  bus
);

    localparam int LINE_BYTES = NUM_BLOCKS * BLOCK_SIZE;
    localparam int NUM_SETS   = CACHE_SIZE / (NUM_WAYS * LINE_BYTES);
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int IDX_W      = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1;
    localparam int TAG_W      = 32 - OFF_W - IDX_W;
    localparam int WAY_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int WORD_W     = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    localparam logic [31:0]       LINE_MASK = 32'(LINE_BYTES - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NUM_BLOCKS - 1);
    localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(NUM_WAYS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state;
    logic [31:0]       lat_addr;
    logic [WORD_W-1:0] k;
    logic [WAY_W-1:0]  vic_way;
    logic [31:0]       rdata_q;

    logic [NUM_SETS-1:0] valid_q  [NUM_WAYS];
    logic [WAY_W-1:0]    rr_ptr   [NUM_SETS];
    logic [TAG_W-1:0]    tag_mem  [NUM_WAYS][NUM_SETS];
    logic [31:0]         data_mem [NUM_WAYS][NUM_SETS][NUM_BLOCKS];

    logic [IDX_W-1:0]  req_idx, lat_idx;
    logic [TAG_W-1:0]  req_tag, lat_tag;
    logic [WORD_W-1:0] req_word, lat_word;

    logic             hit, inv_found;
    logic [WAY_W-1:0] hit_way, inv_way, victim, rr_next;
    logic             fill_hs, fill_last;

    assign req_idx  = IDX_W'(bus.proc_addr >> OFF_W);
    assign req_tag  = TAG_W'(bus.proc_addr >> (OFF_W + IDX_W));
    assign req_word = WORD_W'(bus.proc_addr >> 2);
    assign lat_idx  = IDX_W'(lat_addr >> OFF_W);
    assign lat_tag  = TAG_W'(lat_addr >> (OFF_W + IDX_W));
    assign lat_word = WORD_W'(lat_addr >> 2);

    // Lines are only allocated on a miss, so at most one way can match.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (!hit && valid_q[w][req_idx] && (tag_mem[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !valid_q[w][req_idx]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign victim  = inv_found ? inv_way : rr_ptr[req_idx];
    assign rr_next = (rr_ptr[req_idx] == LAST_WAY) ? '0 : rr_ptr[req_idx] + 1'b1;

    assign fill_hs   = (state == S_FILL) && bus.mem_req_ready;
    assign fill_last = fill_hs && (k == LAST_WORD);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            k        <= '0;
            rdata_q  <= '0;
            lat_addr <= '0;
            vic_way  <= '0;
            for (int unsigned w = 0; w < NUM_WAYS; w++) valid_q[w] <= '0;
            for (int unsigned s = 0; s < NUM_SETS; s++) rr_ptr[s] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.proc_valid) begin
                        lat_addr <= bus.proc_addr;
                        if (hit) begin
                            rdata_q <= data_mem[hit_way][req_idx][req_word];
                            state   <= S_RESP;
                        end else begin
                            vic_way <= victim;
                            k       <= '0;
                            // Pointer only advances when a valid line is evicted.
                            if (!inv_found) rr_ptr[req_idx] <= rr_next;
                            state   <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (fill_hs) begin
                        // Requested word is captured as it streams past, so
                        // the array need not be read back at the end of fill.
                        if (k == lat_word) rdata_q <= bus.mem_req_rdata;
                        if (fill_last) begin
                            valid_q[vic_way][lat_idx] <= 1'b1;
                            k     <= '0;
                            state <= S_RESP;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; validity is tracked by valid_q alone.
    always_ff @(posedge clk) begin
        if (fill_hs) data_mem[vic_way][lat_idx][k] <= bus.mem_req_rdata;
        if (fill_last) tag_mem[vic_way][lat_idx] <= lat_tag;
    end

    assign bus.proc_ready    = (state == S_RESP);
    assign bus.proc_rdata    = rdata_q;
    assign bus.mem_req_valid = (state == S_FILL);
    assign bus.mem_req_addr  = (lat_addr & ~LINE_MASK) + (32'(k) << 2);
    assign bus.debug_miss    = resetn && (state == S_IDLE) && bus.proc_valid && !hit;

endmodule

// File: tb/tb_icache_xwa.sv
// tb_icache_xwa: scoreboard bench for icache_xwa. The driver predicts each
// fetch with a set/tag replacement model and queues the expected response and
// line-fill addresses; a negedge monitor checks responses, fill addresses,
// request stability, miss pulses and latency. Memory returns A ^ 0xA5A5A5A5.
module tb_icache_xwa;

    localparam logic [31:0] PAT  = 32'hA5A5A5A5;
    localparam int          SETS = 64;
    localparam int          WAYS = 4;

    typedef struct {
        logic [31:0] data;
        bit          miss;
        int          issue_cyc;
    } exp_t;

    logic clk;
    logic resetn;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   total_miss = 0;
    int   hs_total = 0;
    int   mem_delay = 0;

    exp_t        exp_q[$];
    logic [31:0] fill_q[$];

    bit          m_valid [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    int          m_rr    [SETS];

    icache_xwa_if bus();

    icache_xwa #(
        .CACHE_SIZE(4096),
        .NUM_WAYS  (4),
        .NUM_BLOCKS(4),
        .BLOCK_SIZE(4)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic model_flush();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endtask

    task automatic model_access(input logic [31:0] a, output bit miss);
        int          s;
        int unsigned t;
        int          v;
        s = int'((a >> 4) % SETS);
        t = a >> 10;
        miss = 1'b1;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == t) miss = 1'b0;
        if (miss) begin
            v = -1;
            for (int w = WAYS - 1; w >= 0; w--)
                if (!m_valid[s][w]) v = w;
            if (v < 0) begin
                v = m_rr[s];
                m_rr[s] = (m_rr[s] + 1) % WAYS;
            end
            m_valid[s][v] = 1'b1;
            m_tag[s][v]   = t;
        end
    endtask

    // Memory: answers each word request after mem_delay wait cycles.
    initial begin : memory
        int  d;
        bit  busy;
        busy = 1'b0;
        d    = 0;
        bus.mem_req_ready = 1'b0;
        bus.mem_req_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_req_ready = 1'b0;
            if (bus.mem_req_valid) begin
                if (!busy) begin
                    busy = 1'b1;
                    d    = mem_delay;
                end
                if (d == 0) begin
                    bus.mem_req_ready = 1'b1;
                    bus.mem_req_rdata = bus.mem_req_addr ^ PAT;
                    busy = 1'b0;
                end else begin
                    d--;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    // Monitor
    int          txn_miss = 0;
    int          txn_hs = 0;
    int          last_hs_cyc = 0;
    bit          prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] fa;
        int          want_cyc;
        if (!resetn) begin
            txn_miss  = 0;
            txn_hs    = 0;
            prev_wait = 1'b0;
        end else begin
            if (bus.debug_miss) begin
                txn_miss++;
                total_miss++;
            end
            if (prev_wait) begin
                check("mem_valid_hold", 32'(bus.mem_req_valid), 32'd1);
                check("mem_addr_hold", bus.mem_req_addr, prev_addr);
            end
            prev_wait = bus.mem_req_valid && !bus.mem_req_ready;
            prev_addr = bus.mem_req_addr;
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                txn_hs++;
                hs_total++;
                last_hs_cyc = cyc;
                if (fill_q.size() == 0) begin
                    check("fill_unexpected", bus.mem_req_addr, 32'hFFFF_FFFF);
                end else begin
                    fa = fill_q.pop_front();
                    check("fill_addr", bus.mem_req_addr, fa);
                end
            end
            if (bus.proc_ready) begin
                if (exp_q.size() == 0) begin
                    check("ready_unexpected", 32'(bus.proc_ready), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    want_cyc = e.miss ? last_hs_cyc + 1 : e.issue_cyc + 1;
                    check("rdata", bus.proc_rdata, e.data);
                    check("miss_pulses", 32'(txn_miss), e.miss ? 32'd1 : 32'd0);
                    check("fill_words", 32'(txn_hs), e.miss ? 32'd4 : 32'd0);
                    check("latency_cycle", 32'(cyc), 32'(want_cyc));
                end
                txn_miss = 0;
                txn_hs   = 0;
            end
        end
    end

    task automatic fetch(input logic [31:0] a);
        exp_t e;
        bit   miss;
        int   n;
        model_access(a, miss);
        e.data = (a & ~32'h3) ^ PAT;
        e.miss = miss;
        if (miss)
            for (int w = 0; w < 4; w++) fill_q.push_back((a & ~32'hF) + 32'(4 * w));
        @(posedge clk);
        #1;
        e.issue_cyc = cyc;
        exp_q.push_back(e);
        bus.proc_valid = 1'b1;
        bus.proc_addr  = a;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!bus.proc_ready && n < 300);
        if (!bus.proc_ready) begin
            check("fetch_timeout", 32'(n), 32'd0);
            finish_run();
        end
        @(posedge clk);
        #1;
        bus.proc_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        bus.proc_valid = 1'b0;
        exp_q.delete();
        fill_q.delete();
        model_flush();
        repeat (n) @(posedge clk);
        @(negedge clk);
        check("rst_proc_ready", 32'(bus.proc_ready), 32'd0);
        check("rst_mem_valid", 32'(bus.mem_req_valid), 32'd0);
        check("rst_debug_miss", 32'(bus.debug_miss), 32'd0);
        check("rst_proc_rdata", bus.proc_rdata, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin : driver
        int          m0;
        int          h0;
        int          n;
        logic [31:0] a;
        logic [31:0] seq [6];
        resetn = 1'b0;
        bus.proc_valid = 1'b0;
        bus.proc_addr  = '0;
        model_flush();
        do_reset(2);

        // Cold miss then hit in the same line.
        m0 = total_miss;
        fetch(32'h0000_0104);
        check("cold_miss_count", 32'(total_miss - m0), 32'd1);
        fetch(32'h0000_010C);
        check("hit_no_new_miss", 32'(total_miss - m0), 32'd1);

        // Five tags into set 16, then the evicted first tag again.
        do_reset(1);
        seq[0] = 32'h100;  seq[1] = 32'h1100; seq[2] = 32'h2100;
        seq[3] = 32'h3100; seq[4] = 32'h4100; seq[5] = 32'h100;
        m0 = total_miss;
        for (int i = 0; i < 6; i++) fetch(seq[i]);
        check("evict_miss_count", 32'(total_miss - m0), 32'd6);
        fetch(32'h2104);
        fetch(32'h1108);

        // Slow memory.
        mem_delay = 3;
        fetch(32'h0000_0848);
        fetch(32'h0000_084C);
        mem_delay = 0;

        // Reset in the middle of a fill of 0x200.
        for (int w = 0; w < 4; w++) fill_q.push_back(32'h200 + 32'(4 * w));
        h0 = hs_total;
        @(posedge clk);
        #1;
        bus.proc_valid = 1'b1;
        bus.proc_addr  = 32'h200;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (hs_total < h0 + 2 && n < 100);
        check("midfill_progress", 32'(hs_total - h0 >= 2), 32'd1);
        do_reset(2);
        m0 = total_miss;
        fetch(32'h200);
        check("refill_after_reset", 32'(total_miss - m0), 32'd1);

        // Straight-line code, two passes.
        do_reset(1);
        m0 = total_miss;
        for (int i = 0; i < 256; i++) fetch(32'(4 * i));
        check("pass1_misses", 32'(total_miss - m0), 32'd64);
        m0 = total_miss;
        for (int i = 0; i < 256; i++) fetch(32'(4 * i));
        check("pass2_misses", 32'(total_miss - m0), 32'd0);

        // Random mix over a few sets with more tags than ways.
        do_reset(1);
        for (int i = 0; i < 400; i++) begin
            a = (32'($urandom_range(0, 5)) << 10)
              | (32'($urandom_range(0, 3) == 3 ? 16 : $urandom_range(0, 2)) << 4)
              | (32'($urandom_range(0, 3)) << 2)
              | 32'($urandom_range(0, 3));
            mem_delay = $urandom_range(0, 3);
            fetch(a);
        end
        mem_delay = 0;

        repeat (3) @(posedge clk);
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        check("fill_queue_drained", 32'(fill_q.size()), 32'd0);
        finish_run();
    end

endmodule
